// File: rtl/shift_unit_seq_if.sv
// Operand/result bundle for the multi-cycle shift unit.
// master drives the request, slave is the shift unit.
interface shift_unit_seq_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [2:0]       mode;
  logic [SHW-1:0]   amount;
  logic [WIDTH-1:0] entry;
  logic [WIDTH-1:0] out;
  logic             carry;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amount, entry,
    input  out, carry, zero, busy, done
  );

  modport slave (
    input  start, mode, amount, entry,
    output out, carry, zero, busy, done
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: one log2 barrel stage per clock, with the
// result, carry-out and zero flag reported through a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | applying stage k (distance 2^k) to the working register
// DONE  | one-cycle result pulse; start here chains the next operation
module shift_unit_seq #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  shift_unit_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] M_SHL = 3'b000;
  localparam logic [2:0] M_SLR = 3'b001;
  localparam logic [2:0] M_SAR = 3'b010;
  localparam logic [2:0] M_ROR = 3'b011;
  localparam logic [2:0] M_ROL = 3'b100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] w, w_stage, out_r;
  logic [2:0]       md;
  logic [SHW-1:0]   amt, k;
  logic             c, c_stage, carry_r, carry_fin;
  logic             accept, last, stage_en;
  int               s;

  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign last     = (k == SHW'(SHW - 1));
  assign stage_en = |(amt & (SHW'(1) << k));

  // One barrel stage; carry is the bit that falls off the end being vacated.
  always_comb begin
    s       = 1 << k;
    w_stage = w;
    c_stage = c;
    if (stage_en) begin
      case (md)
        M_SHL: begin
          w_stage = w << s;
          c_stage = |(w & (WIDTH'(1) << (WIDTH - s)));
        end
        M_SLR: begin
          w_stage = w >> s;
          c_stage = |(w & (WIDTH'(1) << (s - 1)));
        end
        M_SAR: begin
          w_stage = $unsigned($signed(w) >>> s);
          c_stage = |(w & (WIDTH'(1) << (s - 1)));
        end
        M_ROR:   w_stage = (w >> s) | (w << (WIDTH - s));
        M_ROL:   w_stage = (w << s) | (w >> (WIDTH - s));
        default: w_stage = w;
      endcase
    end
  end

  // Rotates report the bit that wrapped last, which ends up at the far edge.
  always_comb begin
    carry_fin = c_stage;
    if (amt == '0)
      carry_fin = 1'b0;
    else if (md == M_ROR)
      carry_fin = w_stage[WIDTH-1];
    else if (md == M_ROL)
      carry_fin = w_stage[0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      w       <= '0;
      md      <= '0;
      amt     <= '0;
      k       <= '0;
      c       <= 1'b0;
      out_r   <= '0;
      carry_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        w   <= bus.entry;
        md  <= bus.mode;
        amt <= bus.amount;
        k   <= '0;
        c   <= 1'b0;
      end else if (state == SHIFT) begin
        w <= w_stage;
        c <= c_stage;
        k <= k + 1'b1;
        if (last) begin
          out_r   <= w_stage;
          carry_r <= carry_fin;
        end
      end
    end
  end

  assign bus.out   = out_r;
  assign bus.carry = carry_r;
  assign bus.zero  = (out_r == '0);
  assign bus.busy  = (state == SHIFT);
  assign bus.done  = (state == DONE);
endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: directed vectors, handshake/reset corners and
// randomized operations checked against an arithmetic reference model.
module tb_shift_unit_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_unit_seq_if #(.WIDTH(32)) bus();
  shift_unit_seq_if #(.WIDTH(8))  bus8();

  shift_unit_seq #(.WIDTH(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  shift_unit_seq #(.WIDTH(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  m;
    logic [4:0]  a;
    logic [31:0] e;
    logic [31:0] o;
    logic        c;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Shifts done on a double-width word so the last bit out lands next to the result.
  function automatic logic [32:0] model(input logic [2:0] m, input logic [4:0] a,
                                        input logic [31:0] e);
    logic [63:0] f;
    logic [31:0] o;
    logic        c;
    o = e;
    c = 1'b0;
    case (m)
      3'd0: begin f = {32'b0, e} << a; o = f[31:0]; c = f[32]; end
      3'd1: begin f = {e, 32'b0} >> a; o = f[63:32]; c = f[31]; end
      3'd2: begin f = $signed({e, 32'b0}) >>> a; o = f[63:32]; c = f[31]; end
      3'd3: begin f = {e, e} >> a; o = f[31:0]; c = o[31]; end
      3'd4: begin f = {e, e} << a; o = f[63:32]; c = o[0]; end
      default: begin o = e; c = 1'b0; end
    endcase
    if (a == 5'd0) c = 1'b0;
    return {c, o};
  endfunction

  always @(negedge clk) begin
    if (bus.busy && bus.done) begin
      errors++;
      $display("FAIL busy_done_overlap32: busy=%0b done=%0b, required not both high", bus.busy, bus.done);
    end
    if (bus8.busy && bus8.done) begin
      errors++;
      $display("FAIL busy_done_overlap8: busy=%0b done=%0b, required not both high", bus8.busy, bus8.done);
    end
  end

  // Caller must be just after a clock edge with the unit in IDLE or DONE.
  task automatic run32(input logic [2:0] m, input logic [4:0] a, input logic [31:0] e,
                       input logic [31:0] eo, input logic ec, input int poke, input string tag);
    int lat;
    bus.start = 1'b1; bus.mode = m; bus.amount = a; bus.entry = e;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mode = 3'($urandom); bus.amount = 5'($urandom); bus.entry = $urandom;
    chk({tag, " busy_at_accept"}, 64'(bus.busy), 64'(1));
    lat = 0;
    while (!bus.done && lat < 20) begin
      bus.start = (lat == poke);
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(5));
    chk({tag, " out"}, 64'(bus.out), 64'(eo));
    chk({tag, " carry"}, 64'(bus.carry), 64'(ec));
    chk({tag, " zero"}, 64'(bus.zero), 64'(eo == 32'd0));
    chk({tag, " busy_at_done"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic run8(input logic [2:0] m, input logic [2:0] a, input logic [7:0] e,
                      input logic [7:0] eo, input logic ec, input string tag);
    int lat;
    bus8.start = 1'b1; bus8.mode = m; bus8.amount = a; bus8.entry = e;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.entry = 8'($urandom);
    lat = 0;
    while (!bus8.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(3));
    chk({tag, " out"}, 64'(bus8.out), 64'(eo));
    chk({tag, " carry"}, 64'(bus8.carry), 64'(ec));
    chk({tag, " zero"}, 64'(bus8.zero), 64'(eo == 8'd0));
  endtask

  initial begin
    logic [2:0]  rm;
    logic [4:0]  ra;
    logic [31:0] re;
    logic [32:0] r;
    logic        saw_done;

    vecs[0] = '{3'd0, 5'd3,  32'h2000_0001, 32'h0000_0008, 1'b1};
    vecs[1] = '{3'd2, 5'd4,  32'h8000_0010, 32'hF800_0001, 1'b0};
    vecs[2] = '{3'd1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[3] = '{3'd3, 5'd2,  32'h4000_0001, 32'h5000_0000, 1'b0};
    vecs[4] = '{3'd4, 5'd1,  32'h8000_0000, 32'h0000_0001, 1'b1};
    vecs[5] = '{3'd0, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[6] = '{3'd7, 5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[7] = '{3'd0, 5'd31, 32'h0000_0002, 32'h0000_0000, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0;  bus.mode = '0;  bus.amount = '0;  bus.entry = '0;
    bus8.start = 1'b0; bus8.mode = '0; bus8.amount = '0; bus8.entry = '0;
    #12;
    chk("reset out", 64'(bus.out), 64'(0));
    chk("reset carry", 64'(bus.carry), 64'(0));
    chk("reset busy", 64'(bus.busy), 64'(0));
    chk("reset done", 64'(bus.done), 64'(0));
    chk("reset zero", 64'(bus.zero), 64'(1));
    chk("reset zero8", 64'(bus8.zero), 64'(1));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run32(vecs[i].m, vecs[i].a, vecs[i].e, vecs[i].o, vecs[i].c, -1, $sformatf("vec%0d", i));
      @(posedge clk); #1;
      chk($sformatf("vec%0d single_done", i), 64'(bus.done), 64'(0));
    end

    // start pulsed mid-operation must be neither honoured nor queued
    run32(3'd0, 5'd3, 32'h2000_0001, 32'h0000_0008, 1'b1, 3, "poke");
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("poke no_requeue", 64'(saw_done), 64'(0));
    chk("poke out_held", 64'(bus.out), 64'h8);

    // back-to-back: second start issued during the DONE cycle
    run32(3'd2, 5'd4, 32'h8000_0010, 32'hF800_0001, 1'b0, -1, "b2b_a");
    run32(3'd4, 5'd1, 32'h8000_0000, 32'h0000_0001, 1'b1, -1, "b2b_b");

    // reset in the middle of an operation
    bus.start = 1'b1; bus.mode = 3'd0; bus.amount = 5'd7; bus.entry = 32'h0000_00FF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst busy", 64'(bus.busy), 64'(0));
    chk("midrst out", 64'(bus.out), 64'(0));
    chk("midrst done", 64'(bus.done), 64'(0));
    chk("midrst zero", 64'(bus.zero), 64'(1));
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("midrst no_done", 64'(saw_done), 64'(0));
    run32(3'd3, 5'd2, 32'h4000_0001, 32'h5000_0000, 1'b0, -1, "after_rst");
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      rm = 3'($urandom);
      ra = 5'($urandom);
      re = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 5'($urandom_range(0, 1) * 31);
      r = model(rm, ra, re);
      run32(rm, ra, re, r[31:0], r[32], -1, $sformatf("rand%0d m%0d a%0d e%08h", i, rm, ra, re));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;

    run8(3'd2, 3'd7, 8'h80, 8'hFF, 1'b0, "w8 sar7");
    run8(3'd0, 3'd1, 8'h81, 8'h02, 1'b1, "w8 shl1");
    run8(3'd3, 3'd3, 8'h01, 8'h20, 1'b0, "w8 ror3");
    run8(3'd4, 3'd4, 8'h3C, 8'hC3, 1'b1, "w8 rol4");
    run8(3'd1, 3'd0, 8'hA5, 8'hA5, 1'b0, "w8 slr0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
